key_debounce_edge_gen: RTL

// - Converts a raw, bouncing push-button (KEY) input into a clean debounced level
//   and single-cycle edge pulses.
// - edgerise_o is the press-event source for enable/toggle logic that expects one

---
 rtl/key_debounce_edge_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/key_debounce_edge_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module      : key_debounce_edge_gen                                         |
// | Description : Debounces a raw push-button pin into a clean pressed level    |
// |               and one-cycle press/release pulses. One instance per key.     |
// | Optional    : define KEY_AUTO_REPEAT_EN to re-pulse edgerise_o every        |
// |               REPEAT_CYCLES+1 cycles while the key stays pressed.           |
// | Ports       : clk_i        system clock                                     |
// |               rst_i        synchronous reset, active-high                   |
// |               key_i        raw asynchronous button pin                      |
// |               key_level_o  debounced level, 1 = pressed                     |
// |               edgerise_o   one-cycle pulse on accepted press                |
// |               edgefall_o   one-cycle pulse on accepted release              |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module key_debounce_edge_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic key_level_o,
    output logic edgerise_o,
    output logic edgefall_o
);

    localparam int                 c_cnt_w        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max      = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
    // Pin level when the key is not pressed; also the XOR mask that normalises it.
    localparam logic               c_pin_released = (KEY_ACTIVE_LOW != 0);

    localparam logic [1:0] c_st_released     = 2'd0;
    localparam logic [1:0] c_st_press_pend   = 2'd1;
    localparam logic [1:0] c_st_pressed      = 2'd2;
    localparam logic [1:0] c_st_release_pend = 2'd3;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_s;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_level_nxt;
    logic               w_rise_acc;
    logic               w_rise_rpt;
    logic               w_fall;

    // Synchroniser; reset preloads the released level so a key already held
    // when reset lifts is seen as a fresh press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= c_pin_released;
            r_sync2 <= c_pin_released;
        end else begin
            r_sync1 <= key_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ c_pin_released;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_released: begin
                if (w_s) begin
                    w_state_nxt = c_st_press_pend;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            c_st_press_pend: begin
                if (!w_s) begin
                    w_state_nxt = c_st_released;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = c_st_pressed;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            c_st_pressed: begin
                if (!w_s) begin
                    w_state_nxt = c_st_release_pend;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            c_st_release_pend: begin
                if (w_s) begin
                    w_state_nxt = c_st_pressed;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = c_st_released;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = c_st_released;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pulses fire only on completed debounce transitions, never on reset.
    assign w_rise_acc  = (r_state == c_st_press_pend)   && (w_state_nxt == c_st_pressed);
    assign w_fall      = (r_state == c_st_release_pend) && (w_state_nxt == c_st_released);
    assign w_level_nxt = (w_state_nxt == c_st_pressed) || (w_state_nxt == c_st_release_pend);

`ifdef KEY_AUTO_REPEAT_EN
    localparam int                 c_rpt_w   = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rpt_w-1:0] c_rpt_max = c_rpt_w'(REPEAT_CYCLES);
    localparam logic [c_rpt_w-1:0] c_rpt_one = c_rpt_w'(1);

    logic [c_rpt_w-1:0] r_rpt;
    logic [c_rpt_w-1:0] w_rpt_nxt;

    // Counts only while stably pressed; a release bounce holds the count so a
    // rejected release resumes the repeat cadence instead of restarting it.
    always_comb begin
        w_rpt_nxt  = '0;
        w_rise_rpt = 1'b0;
        case (r_state)
            c_st_pressed: begin
                if (!w_s) begin
                    w_rpt_nxt = r_rpt;
                end else if (r_rpt == c_rpt_max) begin
                    w_rise_rpt = 1'b1;
                    w_rpt_nxt  = '0;
                end else begin
                    w_rpt_nxt  = r_rpt + c_rpt_one;
                end
            end
            c_st_release_pend: w_rpt_nxt = r_rpt;
            default:           w_rpt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rpt <= '0;
        end else begin
            r_rpt <= w_rpt_nxt;
        end
    end
`else
    assign w_rise_rpt = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_st_released;
            r_cnt       <= '0;
            key_level_o <= 1'b0;
            edgerise_o  <= 1'b0;
            edgefall_o  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            key_level_o <= w_level_nxt;
            edgerise_o  <= w_rise_acc | w_rise_rpt;
            edgefall_o  <= w_fall;
        end
    end

endmodule
`default_nettype wire
